// File: rtl/motor_pkg.sv
// Shared types for the motor command path: controller state encoding, duty width,
// and a saturating step-down helper used by the ramp logic.
package motor_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DWELL = 2'd2,
    ESTOP = 2'd3
  } motor_state_t;

  // Moves cur down by step without passing floor_v; caller guarantees cur >= floor_v.
  function automatic logic [DUTY_W-1:0] step_down(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] floor_v,
    input logic [DUTY_W-1:0] step
  );
    return ((cur - floor_v) > step) ? (cur - step) : floor_v;
  endfunction

endpackage

// File: rtl/motor_tick_gen.sv
// Free-running divider: tick is high for one cycle every DIV cycles (count DIV-1).
module motor_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/motor_ramp.sv
// Soft-start/soft-stop stage ahead of motor_drv: slews duty one step per tick, reverses via
// zero + dwell, estop forces off. Define MOTOR_RAMP_FAST_DECEL_EN for 2-LSB deceleration steps.
module motor_ramp
  import motor_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int STEP_HZ     = 1000,
  parameter int DWELL_TICKS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_dir,
  input  logic              estop,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              direction,
  output logic              enable,
  output logic              at_target
);

  localparam int TICK_DIV = CLK_HZ / STEP_HZ;
  localparam int DW_W     = $clog2(DWELL_TICKS + 1);

`ifdef MOTOR_RAMP_FAST_DECEL_EN
  localparam logic [DUTY_W-1:0] DEC_STEP = DUTY_W'(2);
`else
  localparam logic [DUTY_W-1:0] DEC_STEP = DUTY_W'(1);
`endif

  logic tick;

  motor_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  motor_state_t      state_q, state_d;
  logic [DUTY_W-1:0] tgt_duty_q, tgt_duty_d;
  logic              tgt_dir_q, tgt_dir_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;
  logic              enable_q, enable_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              at_target_q, at_target_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;

  always_comb begin
    state_d    = state_q;
    tgt_duty_d = tgt_duty_q;
    tgt_dir_d  = tgt_dir_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    dwell_d    = dwell_q;

    if (cmd_valid && cmd_ready_q) begin
      tgt_duty_d = cmd_duty;
      tgt_dir_d  = cmd_dir;
    end

    // Decisions use the registered target, so a command landing on a tick takes effect next tick.
    case (state_q)
      IDLE: begin
        duty_d = '0;
        if (tgt_duty_q != '0) begin
          dir_d   = tgt_dir_q;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          if (tgt_dir_q != dir_q) begin
            duty_d = step_down(duty_q, '0, DEC_STEP);
            if (duty_d == '0) begin
              state_d = DWELL;
              dwell_d = '0;
            end
          end else if (duty_q < tgt_duty_q) begin
            duty_d = duty_q + DUTY_W'(1);
          end else if (duty_q > tgt_duty_q) begin
            duty_d = step_down(duty_q, tgt_duty_q, DEC_STEP);
          end else if (duty_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      DWELL: begin
        duty_d = '0;
        if (tick) begin
          dwell_d = dwell_q + DW_W'(1);
          if (dwell_d == DW_W'(DWELL_TICKS)) begin
            dir_d   = tgt_dir_q;
            dwell_d = '0;
            state_d = (tgt_duty_q != '0) ? RUN : IDLE;
          end
        end
      end
      ESTOP: begin
        duty_d = '0;
        if (!estop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (estop) begin
      state_d    = ESTOP;
      duty_d     = '0;
      tgt_duty_d = '0;
      dwell_d    = '0;
      dir_d      = dir_q;
    end

    enable_d    = (state_d == RUN) || (state_d == DWELL);
    cmd_ready_d = (state_d != ESTOP);
    at_target_d = ((state_d == RUN) && (duty_d == tgt_duty_d) && (dir_d == tgt_dir_d)) ||
                  ((state_d == IDLE) && (tgt_duty_d == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tgt_duty_q  <= '0;
      tgt_dir_q   <= 1'b0;
      duty_q      <= '0;
      dir_q       <= 1'b0;
      enable_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      at_target_q <= 1'b1;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      tgt_duty_q  <= tgt_duty_d;
      tgt_dir_q   <= tgt_dir_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      enable_q    <= enable_d;
      cmd_ready_q <= cmd_ready_d;
      at_target_q <= at_target_d;
      dwell_q     <= dwell_d;
    end
  end

  assign duty_cycle = duty_q;
  assign direction  = dir_q;
  assign enable     = enable_q;
  assign cmd_ready  = cmd_ready_q;
  assign at_target  = at_target_q;

endmodule

// File: tb/tb_motor_ramp.sv
// Scenario bench for motor_ramp: per-tick duty/direction/enable predicted from the ramp rules.
module tb_motor_ramp;

  localparam int DW  = 4;
  localparam int DIV = 10;
`ifdef MOTOR_RAMP_FAST_DECEL_EN
  localparam int DEC = 2;
`else
  localparam int DEC = 1;
`endif

  typedef struct {
    int duty;
    bit dir;
    bit en;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_duty = 8'd0;
  logic       cmd_dir = 1'b0;
  logic       estop = 1'b0;
  logic       cmd_ready;
  logic [7:0] duty_cycle;
  logic       direction;
  logic       enable;
  logic       at_target;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Bench's belief of the controller: current duty/direction, target, and whether it is running.
  int m_duty = 0;
  int m_tgt  = 0;
  bit m_dir  = 1'b0;
  bit m_run  = 1'b0;

  always #5 clk = ~clk;

  motor_ramp #(
    .CLK_HZ      (1000),
    .STEP_HZ     (100),
    .DWELL_TICKS (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_duty   (cmd_duty),
    .cmd_dir    (cmd_dir),
    .estop      (estop),
    .duty_cycle (duty_cycle),
    .direction  (direction),
    .enable     (enable),
    .at_target  (at_target)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Tick edges are those after which cyc % DIV == 0.
  task automatic wait_phase(input int p);
    do step(); while (cyc % DIV != p);
  endtask

  task automatic run_to(input int t, input bit d, input int max_ticks, input int phase,
                        input string name);
    exp_t q[$];
    int   cur;
    bit   cdir;
    bit   pend;
    int   n;
    cur  = m_duty;
    cdir = m_dir;
    if (phase == 9 && m_run && d == cdir) begin
      if (cur < m_tgt) cur++;
      else if (cur > m_tgt) cur = (cur - m_tgt > DEC) ? cur - DEC : m_tgt;
      q.push_back('{duty: cur, dir: cdir, en: 1'b1});
    end
    if (!m_run) begin
      if (t != 0) begin
        for (int v = 1; v <= t; v++) q.push_back('{duty: v, dir: d, en: 1'b1});
      end
    end else if (d != cdir) begin
      while (cur > 0) begin
        cur = (cur > DEC) ? cur - DEC : 0;
        q.push_back('{duty: cur, dir: cdir, en: 1'b1});
      end
      for (int k = 1; k <= DW; k++)
        q.push_back('{duty: 0, dir: (k == DW) ? d : cdir, en: (k == DW) ? (t != 0) : 1'b1});
      for (int v = 1; v <= t; v++) q.push_back('{duty: v, dir: d, en: 1'b1});
    end else begin
      while (cur != t) begin
        if (cur < t) cur++;
        else cur = (cur - t > DEC) ? cur - DEC : t;
        q.push_back('{duty: cur, dir: cdir, en: 1'b1});
      end
      if (t == 0) q.push_back('{duty: 0, dir: cdir, en: 1'b0});
    end

    wait_phase(phase);
    cmd_valid = 1'b1;
    cmd_duty  = t[7:0];
    cmd_dir   = d;
    step();
    cmd_valid = 1'b0;
    pend = (cyc % DIV == 0);

    if (!m_run && t != 0) begin
      step();
      n_checks++;
      if (enable !== 1'b1 || duty_cycle !== 8'd0 || direction !== d)
        $display("FAIL %s_start: en=%b duty=%0d dir=%b, want en=1 duty=0 dir=%b",
                 name, enable, duty_cycle, direction, d);
      else n_pass++;
    end

    n = (q.size() < max_ticks) ? q.size() : max_ticks;
    for (int i = 0; i < n; i++) begin
      if (!pend) begin
        do step(); while (cyc % DIV != 0);
      end
      pend = 1'b0;
      n_checks++;
      if (duty_cycle !== q[i].duty[7:0])
        $display("FAIL %s_duty tick %0d: got %0d want %0d", name, i, duty_cycle, q[i].duty);
      else n_pass++;
      n_checks++;
      if (direction !== q[i].dir)
        $display("FAIL %s_dir tick %0d: got %b want %b", name, i, direction, q[i].dir);
      else n_pass++;
      n_checks++;
      if (enable !== q[i].en)
        $display("FAIL %s_en tick %0d: got %b want %b", name, i, enable, q[i].en);
      else n_pass++;
    end

    n_checks++;
    if (at_target !== (n == q.size()))
      $display("FAIL %s_at_target: got %b want %b", name, at_target, (n == q.size()));
    else n_pass++;

    if (n > 0) begin
      m_duty = q[n-1].duty;
      m_dir  = q[n-1].dir;
      m_run  = q[n-1].en;
    end
    m_tgt = t;
    $display("cmd %s: duty %0d dir %0d, %0d ticks observed, duty now %0d", name, t, d, n, m_duty);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    n_checks++;
    if (duty_cycle !== 8'd0) $display("FAIL rst_duty: got %0d want 0", duty_cycle);
    else n_pass++;
    n_checks++;
    if (direction !== 1'b0) $display("FAIL rst_dir: got %b want 0", direction);
    else n_pass++;
    n_checks++;
    if (enable !== 1'b0) $display("FAIL rst_enable: got %b want 0", enable);
    else n_pass++;
    n_checks++;
    if (cmd_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", cmd_ready);
    else n_pass++;
    n_checks++;
    if (at_target !== 1'b1) $display("FAIL rst_at_target: got %b want 1", at_target);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    repeat (3) step();
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", cmd_ready);
    else n_pass++;
    n_checks++;
    if (at_target !== 1'b1) $display("FAIL idle_at_target: got %b want 1", at_target);
    else n_pass++;
    n_checks++;
    if (enable !== 1'b0 || duty_cycle !== 8'd0)
      $display("FAIL idle_out: en=%b duty=%0d want en=0 duty=0", enable, duty_cycle);
    else n_pass++;
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_accel();
    run_to(128, 1'b0, 100000, 1, "accel");
  endtask

  task automatic test_reversal();
    run_to(50, 1'b1, 100000, 2, "reverse");
  endtask

  task automatic test_mid_ramp();
    run_to(200, 1'b1, 10, 1, "mid_up");
    run_to(40, 1'b1, 100000, 1, "mid_down");
  endtask

  task automatic test_back_to_back();
    run_to(100, 1'b1, 20, 1, "b2b_up");
    run_to(30, 1'b1, 100000, 9, "b2b_on_tick");
  endtask

  task automatic test_estop();
    run_to(90, 1'b0, 100000, 4, "estop_setup");
    wait_phase(3);
    estop = 1'b1;
    step();
    n_checks++;
    if (duty_cycle !== 8'd0 || enable !== 1'b0)
      $display("FAIL estop_off: duty=%0d en=%b want 0/0", duty_cycle, enable);
    else n_pass++;
    n_checks++;
    if (cmd_ready !== 1'b0) $display("FAIL estop_ready: got %b want 0", cmd_ready);
    else n_pass++;
    n_checks++;
    if (direction !== m_dir) $display("FAIL estop_dir: got %b want %b", direction, m_dir);
    else n_pass++;
    cmd_valid = 1'b1;
    cmd_duty  = 8'd77;
    cmd_dir   = 1'b1;
    repeat (5) step();
    n_checks++;
    if (cmd_ready !== 1'b0 || at_target !== 1'b0)
      $display("FAIL estop_hold: ready=%b at_target=%b want 0/0", cmd_ready, at_target);
    else n_pass++;
    estop     = 1'b0;
    cmd_valid = 1'b0;
    step();
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL estop_release_ready: got %b want 1", cmd_ready);
    else n_pass++;
    repeat (25) step();
    n_checks++;
    if (enable !== 1'b0 || duty_cycle !== 8'd0 || at_target !== 1'b1)
      $display("FAIL estop_no_cmd: en=%b duty=%0d at_target=%b want 0/0/1",
               enable, duty_cycle, at_target);
    else n_pass++;
    m_duty = 0;
    m_tgt  = 0;
    m_run  = 1'b0;
    $display("estop: forced off, command during estop dropped");
  endtask

  task automatic test_full_scale();
    run_to(255, 1'b1, 100000, 5, "full_up");
    do step(); while (cyc % DIV != 0);
    n_checks++;
    if (duty_cycle !== 8'd255 || at_target !== 1'b1)
      $display("FAIL full_hold: duty=%0d at_target=%b want 255/1", duty_cycle, at_target);
    else n_pass++;
    run_to(0, 1'b1, 100000, 6, "full_down");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      run_to(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 100000,
             int'($urandom_range(0, 8)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_reversal();
    test_mid_ramp();
    test_back_to_back();
    test_estop();
    test_full_scale();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
